// File: rtl/slot_alloc_pkg.sv
// Shared types and width helpers for the circular slot allocator.
package slot_alloc_pkg;

  typedef enum logic {SA_RR, SA_LOWEST} mode_t;

  function automatic int unsigned idx_w(int unsigned w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  function automatic int unsigned cnt_w(int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/circ_find0.sv
// Combinational circular first-zero finder: lowest 0 in x at or above pos, else lowest 0 overall.
module circ_find0
  import slot_alloc_pkg::*;
#(
  parameter int unsigned W  = 16,
  parameter int unsigned IW = idx_w(W)
) (
  input  logic [W-1:0]  x,
  input  logic [IW-1:0] pos,
  output logic [W-1:0]  oh,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [W-1:0] masked;
  logic [W-1:0] oh_hi;
  logic [W-1:0] oh_lo;
  logic         found_hi;
  logic         found_lo;

  always_comb begin
    masked   = x;
    oh_hi    = '0;
    oh_lo    = '0;
    found_hi = 1'b0;
    found_lo = 1'b0;
    // Bits below pos are treated as taken so the first pass only sees the upper part.
    for (int i = 0; i < W; i++) begin
      if (IW'(i) < pos) masked[i] = 1'b1;
    end
    for (int i = 0; i < W; i++) begin
      if (!masked[i] && !found_hi) begin
        oh_hi[i] = 1'b1;
        found_hi = 1'b1;
      end
      if (!x[i] && !found_lo) begin
        oh_lo[i] = 1'b1;
        found_lo = 1'b1;
      end
    end
  end

  always_comb begin
    oh  = found_hi ? oh_hi : oh_lo;
    any = found_lo;
    idx = '0;
    for (int i = 0; i < W; i++) begin
      if (oh[i]) idx = idx | IW'(i);
    end
  end

endmodule

// File: rtl/slot_alloc.sv
// Circular free-slot allocator: one grant and one retire per cycle, with occupancy count and
// illegal-free detection.
module slot_alloc
  import slot_alloc_pkg::*;
#(
  parameter int unsigned W    = 16,
  parameter mode_t       MODE = SA_RR,
  localparam int unsigned IW  = idx_w(W),
  localparam int unsigned CW  = cnt_w(W)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush_i,
  input  logic          alloc_ready_i,
  output logic          alloc_valid_o,
  output logic [IW-1:0] alloc_idx_o,
  output logic [W-1:0]  alloc_oh_o,
  input  logic          free_valid_i,
  input  logic [IW-1:0] free_idx_i,
  output logic [W-1:0]  occ_o,
  output logic [CW-1:0] cnt_o,
  output logic          full_o,
  output logic          empty_o,
  output logic          err_o
);

  logic [W-1:0]  occ_q, occ_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;

  logic [W-1:0]  find_oh;
  logic [IW-1:0] find_idx;
  logic          find_any;
  logic [W-1:0]  free_oh;
  logic          alloc_fire;
  logic          free_legal;

  circ_find0 #(
    .W  (W),
    .IW (IW)
  ) u_find (
    .x   (occ_q),
    .pos (ptr_q),
    .oh  (find_oh),
    .idx (find_idx),
    .any (find_any)
  );

  always_comb begin
    full_o        = (cnt_q == CW'(W));
    empty_o       = (cnt_q == '0);
    alloc_valid_o = ~full_o;
    alloc_idx_o   = (alloc_valid_o && find_any) ? find_idx : '0;
    alloc_oh_o    = (alloc_valid_o && find_any) ? find_oh : '0;
    occ_o         = occ_q;
    cnt_o         = cnt_q;
    err_o         = err_q;
  end

  always_comb begin
    // Decoding through a loop keeps out-of-range indices from ever addressing occ_q.
    free_oh = '0;
    for (int i = 0; i < W; i++) begin
      if (free_idx_i == IW'(i)) free_oh[i] = 1'b1;
    end
    alloc_fire = alloc_valid_o & alloc_ready_i & ~flush_i;
    free_legal = free_valid_i & ~flush_i & (|(free_oh & occ_q));

    occ_d = occ_q;
    ptr_d = ptr_q;
    cnt_d = cnt_q + CW'(alloc_fire) - CW'(free_legal);
    err_d = free_valid_i & ~flush_i & ~free_legal;

    if (alloc_fire) begin
      occ_d = occ_d | alloc_oh_o;
      if (MODE == SA_RR) begin
        ptr_d = (alloc_idx_o == IW'(W - 1)) ? '0 : alloc_idx_o + 1'b1;
      end
    end
    if (free_legal) occ_d = occ_d & ~free_oh;

    if (flush_i) begin
      occ_d = '0;
      ptr_d = '0;
      cnt_d = '0;
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      occ_q <= '0;
      ptr_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      occ_q <= occ_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

endmodule

// File: tb/tb_slot_alloc.sv
// Bench for slot_alloc: three instances (W=8 RR, W=8 lowest, W=6 RR) against a slot-array model.
module tb_slot_alloc;
  import slot_alloc_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush_i = 1'b0;
  logic       alloc_ready_i = 1'b0;
  logic       free_valid_i = 1'b0;
  logic [2:0] free_idx_i = '0;

  logic       v_rr, v_lo, v_w6;
  logic [2:0] i_rr, i_lo, i_w6;
  logic [7:0] oh_rr, oh_lo, occ_rr, occ_lo;
  logic [5:0] oh_w6, occ_w6;
  logic [3:0] c_rr, c_lo;
  logic [2:0] c_w6;
  logic       f_rr, f_lo, f_w6, e_rr, e_lo, e_w6, r_rr, r_lo, r_w6;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  slot_alloc #(.W(8), .MODE(SA_RR)) u_rr (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i), .alloc_ready_i(alloc_ready_i),
    .alloc_valid_o(v_rr), .alloc_idx_o(i_rr), .alloc_oh_o(oh_rr),
    .free_valid_i(free_valid_i), .free_idx_i(free_idx_i), .occ_o(occ_rr), .cnt_o(c_rr),
    .full_o(f_rr), .empty_o(e_rr), .err_o(r_rr)
  );

  slot_alloc #(.W(8), .MODE(SA_LOWEST)) u_lo (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i), .alloc_ready_i(alloc_ready_i),
    .alloc_valid_o(v_lo), .alloc_idx_o(i_lo), .alloc_oh_o(oh_lo),
    .free_valid_i(free_valid_i), .free_idx_i(free_idx_i), .occ_o(occ_lo), .cnt_o(c_lo),
    .full_o(f_lo), .empty_o(e_lo), .err_o(r_lo)
  );

  slot_alloc #(.W(6), .MODE(SA_RR)) u_w6 (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i), .alloc_ready_i(alloc_ready_i),
    .alloc_valid_o(v_w6), .alloc_idx_o(i_w6), .alloc_oh_o(oh_w6),
    .free_valid_i(free_valid_i), .free_idx_i(free_idx_i), .occ_o(occ_w6), .cnt_o(c_w6),
    .full_o(f_w6), .empty_o(e_w6), .err_o(r_w6)
  );

  // Reference model: per instance a slot array, a search start and a pending error flag.
  int ws[3]       = '{8, 8, 6};
  bit lowest[3]   = '{1'b0, 1'b1, 1'b0};
  bit m_occ[3][8];
  int m_ptr[3];
  bit m_err[3];

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int model_find(input int n);
    for (int j = 0; j < ws[n]; j++) begin
      int k;
      k = (m_ptr[n] + j) % ws[n];
      if (!m_occ[n][k]) return k;
    end
    return -1;
  endfunction

  function automatic int model_cnt(input int n);
    int c;
    c = 0;
    for (int k = 0; k < ws[n]; k++) c += int'(m_occ[n][k]);
    return c;
  endfunction

  function automatic int model_vec(input int n);
    int v;
    v = 0;
    for (int k = 0; k < ws[n]; k++) if (m_occ[n][k]) v += (1 << k);
    return v;
  endfunction

  task automatic check_inst(input string nm, input int n, input int v, input int idx,
                            input int oh, input int occ, input int cnt, input int full,
                            input int empty, input int err);
    int k, c;
    k = model_find(n);
    c = model_cnt(n);
    check({nm, ".valid"}, v, int'(k >= 0));
    check({nm, ".idx"}, idx, (k >= 0) ? k : 0);
    check({nm, ".oh"}, oh, (k >= 0) ? (1 << k) : 0);
    check({nm, ".occ"}, occ, model_vec(n));
    check({nm, ".cnt"}, cnt, c);
    check({nm, ".full"}, full, int'(c == ws[n]));
    check({nm, ".empty"}, empty, int'(c == 0));
    check({nm, ".err"}, err, int'(m_err[n]));
  endtask

  task automatic check_all();
    check_inst("rr", 0, int'(v_rr), int'(i_rr), int'(oh_rr), int'(occ_rr), int'(c_rr),
               int'(f_rr), int'(e_rr), int'(r_rr));
    check_inst("lo", 1, int'(v_lo), int'(i_lo), int'(oh_lo), int'(occ_lo), int'(c_lo),
               int'(f_lo), int'(e_lo), int'(r_lo));
    check_inst("w6", 2, int'(v_w6), int'(i_w6), int'(oh_w6), int'(occ_w6), int'(c_w6),
               int'(f_w6), int'(e_w6), int'(r_w6));
  endtask

  // Advance model and DUTs by one clock with the currently driven inputs, then compare.
  task automatic step();
    for (int n = 0; n < 3; n++) begin
      int k, fi;
      k  = model_find(n);
      fi = int'(free_idx_i);
      m_err[n] = 1'b0;
      if (!rst_n || flush_i) begin
        for (int j = 0; j < 8; j++) m_occ[n][j] = 1'b0;
        m_ptr[n] = 0;
      end else begin
        if (free_valid_i) begin
          if (fi < ws[n] && m_occ[n][fi]) m_occ[n][fi] = 1'b0;
          else m_err[n] = 1'b1;
        end
        if (alloc_ready_i && k >= 0) begin
          m_occ[n][k] = 1'b1;
          m_ptr[n] = lowest[n] ? 0 : (k + 1) % ws[n];
        end
      end
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic drive(input bit rdy, input bit fv, input int fidx);
    alloc_ready_i = rdy;
    free_valid_i  = fv;
    free_idx_i    = 3'(fidx);
  endtask

  initial begin
    // Reset and fill.
    rst_n = 1'b0;
    step();
    check("rst.idx0", int'(i_rr), 0);
    check("rst.oh1", int'(oh_rr), 1);
    rst_n = 1'b1;
    drive(1, 0, 0);
    for (int i = 0; i < 8; i++) begin
      check("fill.grant", int'(i_rr), i);
      step();
    end
    check("fill.cnt8", int'(c_rr), 8);
    check("fill.full", int'(f_rr), 1);
    check("fill.valid0", int'(v_rr), 0);

    // Round-robin wrap: free 2 and 6 with the pointer back at 0.
    drive(0, 1, 2); step();
    drive(0, 1, 6); step();
    drive(1, 0, 0);
    check("wrap.grant2", int'(i_rr), 2);
    step();
    check("wrap.grant6", int'(i_rr), 6);
    step();

    // Lowest-index policy on occ = 1011_0101.
    drive(0, 1, 1); step();
    drive(0, 1, 3); step();
    drive(0, 1, 6); step();
    check("low.occ", int'(occ_lo), 8'hB5);
    check("low.idx1", int'(i_lo), 1);
    drive(0, 1, 0); step();
    check("low.idx0", int'(i_lo), 0);

    // Simultaneous grant and retire keep the count.
    drive(1, 1, 7); step();
    check("sim.cnt", int'(c_rr), 4);

    // Illegal frees: already-free slot, and out of range on W=6.
    drive(0, 1, 3); step();
    check("ill.err", int'(r_rr), 1);
    drive(0, 1, 7); step();
    check("w6.err", int'(r_w6), 1);
    drive(0, 0, 0); step();
    check("ill.pulse", int'(r_rr), 0);

    // Flush wins over alloc and free.
    drive(1, 1, 2); flush_i = 1'b1; step();
    flush_i = 1'b0;
    check("flush.cnt", int'(c_rr), 0);
    check("flush.occ", int'(occ_rr), 0);

    // Randomized traffic with occasional flush and reset.
    for (int t = 0; t < 3000; t++) begin
      drive(($urandom_range(0, 9) < 6), ($urandom_range(0, 9) < 6), int'($urandom_range(0, 7)));
      flush_i = ($urandom_range(0, 99) == 0);
      rst_n   = ($urandom_range(0, 199) != 0);
      step();
    end

    // Mid-run reset.
    rst_n = 1'b1; flush_i = 1'b0;
    drive(1, 0, 0);
    for (int i = 0; i < 5; i++) step();
    rst_n = 1'b0; drive(1, 1, 0); step();
    check("mrst.cnt", int'(c_rr), 0);
    check("mrst.empty", int'(e_rr), 1);
    check("mrst.idx", int'(i_rr), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
